// File: rtl/sram_arbiter.sv
// Arbiter/sequencer sharing a single-port synchronous SRAM between the display read
// path (priority) and the game read/write path, with a bounded game wait.
module sram_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     disp_req,
    input  logic [ADDRESS_WIDTH-1:0] disp_addr,
    output logic                     disp_gnt,
    output logic                     disp_valid,
    output logic [DATA_WIDTH-1:0]    disp_data,
    input  logic                     game_req,
    input  logic                     game_we,
    input  logic [ADDRESS_WIDTH-1:0] game_addr,
    input  logic [DATA_WIDTH-1:0]    game_wdata,
    output logic                     game_gnt,
    output logic                     game_rvalid,
    output logic [DATA_WIDTH-1:0]    game_rdata,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic                     sram_enable,
    output logic [DATA_WIDTH-1:0]    sram_wdata,
    input  logic [DATA_WIDTH-1:0]    sram_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_GAME = 2'd2
    } tag_t;

    logic [WAIT_W-1:0]        wait_cnt_r;
    logic [WAIT_W-1:0]        wait_cnt_nxt_s;
    tag_t                     tag_r;
    tag_t                     tag_nxt_s;
    logic [ADDRESS_WIDTH-1:0] sram_address_r;
    logic [ADDRESS_WIDTH-1:0] sram_address_nxt_s;
    logic [DATA_WIDTH-1:0]    sram_wdata_r;
    logic [DATA_WIDTH-1:0]    sram_wdata_nxt_s;
    logic                     sram_enable_r;
    logic                     sram_enable_nxt_s;
    logic                     disp_valid_r;
    logic                     game_rvalid_r;
    logic                     force_game_s;
    logic                     disp_gnt_s;
    logic                     game_gnt_s;

    // Grant decision: display wins unless the game has waited MAX_WAIT cycles.
    always_comb begin
        force_game_s = game_req && (wait_cnt_r >= WAIT_W'(MAX_WAIT));
        game_gnt_s   = RST_N && game_req && (!disp_req || force_game_s);
        disp_gnt_s   = RST_N && disp_req && !force_game_s;
    end

    // Starvation counter next value, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (!game_req || game_gnt_s) begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (wait_cnt_r != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Issue stage: address/data hold when idle so the SRAM just re-reads harmlessly.
    always_comb begin
        sram_address_nxt_s = sram_address_r;
        sram_wdata_nxt_s   = sram_wdata_r;
        sram_enable_nxt_s  = 1'b0;
        tag_nxt_s          = TAG_NONE;
        if (game_gnt_s) begin
            sram_address_nxt_s = game_addr;
            if (game_we) begin
                sram_wdata_nxt_s  = game_wdata;
                sram_enable_nxt_s = 1'b1;
                tag_nxt_s         = TAG_NONE;
            end else begin
                sram_enable_nxt_s = 1'b0;
                tag_nxt_s         = TAG_GAME;
            end
        end else if (disp_gnt_s) begin
            sram_address_nxt_s = disp_addr;
            sram_enable_nxt_s  = 1'b0;
            tag_nxt_s          = TAG_DISP;
        end else begin
            sram_enable_nxt_s = 1'b0;
            tag_nxt_s         = TAG_NONE;
        end
    end

    // State registers; clearing the tag on reset drops any read in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_r     <= {WAIT_W{1'b0}};
            tag_r          <= TAG_NONE;
            sram_address_r <= {ADDRESS_WIDTH{1'b0}};
            sram_wdata_r   <= {DATA_WIDTH{1'b0}};
            sram_enable_r  <= 1'b0;
            disp_valid_r   <= 1'b0;
            game_rvalid_r  <= 1'b0;
        end else begin
            wait_cnt_r     <= wait_cnt_nxt_s;
            tag_r          <= tag_nxt_s;
            sram_address_r <= sram_address_nxt_s;
            sram_wdata_r   <= sram_wdata_nxt_s;
            sram_enable_r  <= sram_enable_nxt_s;
            disp_valid_r   <= (tag_r == TAG_DISP);
            game_rvalid_r  <= (tag_r == TAG_GAME);
        end
    end

    assign disp_gnt     = disp_gnt_s;
    assign game_gnt     = game_gnt_s;
    assign sram_address = sram_address_r;
    assign sram_wdata   = sram_wdata_r;
    assign sram_enable  = sram_enable_r;
    assign disp_valid   = disp_valid_r;
    assign game_rvalid  = game_rvalid_r;
    assign disp_data    = sram_rdata;
    assign game_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table for grants plus a read-data
// scoreboard checked against a behavioural synchronous SRAM.
module tb_sram_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_gnt;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        game_req;
    logic        game_we;
    logic [15:0] game_addr;
    logic [7:0]  game_wdata;
    logic        game_gnt;
    logic        game_rvalid;
    logic [7:0]  game_rdata;
    logic [15:0] sram_address;
    logic        sram_enable;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;

    logic        pre_en;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t disp_q[$];
    exp_t game_q[$];

    typedef struct {
        logic        dreq;
        logic [15:0] daddr;
        logic        greq;
        logic        gwe;
        logic [15:0] gaddr;
        logic [7:0]  gwd;
        logic        edg;
        logic        egg;
    } vec_t;
    vec_t vecs[19];

    sram_arbiter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_gnt(game_gnt),
        .game_rvalid(game_rvalid), .game_rdata(game_rdata),
        .sram_address(sram_address), .sram_enable(sram_enable),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural single-port synchronous SRAM with a bench-only preload port.
    always @(posedge CLK) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (sram_enable) mem[sram_address] <= sram_wdata;
        sram_rdata <= mem[sram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        disp_req   = v.dreq;
        disp_addr  = v.daddr;
        game_req   = v.greq;
        game_we    = v.gwe;
        game_addr  = v.gaddr;
        game_wdata = v.gwd;
    endtask

    task automatic run_row(input vec_t v, input int idx);
        exp_t e;
        @(posedge CLK);
        #1;
        drive(v);
        @(negedge CLK);
        chk($sformatf("disp_gnt[%0d]", idx), {31'd0, disp_gnt}, {31'd0, v.edg});
        chk($sformatf("game_gnt[%0d]", idx), {31'd0, game_gnt}, {31'd0, v.egg});
        if (v.egg) begin
            if (v.gwe) begin
                ref_mem[v.gaddr] = v.gwd;
            end else begin
                e.data = ref_mem[v.gaddr];
                e.due  = cyc + 2;
                game_q.push_back(e);
            end
        end else if (v.edg) begin
            e.data = ref_mem[v.daddr];
            e.due  = cyc + 2;
            disp_q.push_back(e);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(posedge CLK);
        #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(posedge CLK);
        #1;
        pre_en = 1'b0;
    endtask

    // Return-path monitor: every valid must match the head of its scoreboard, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                if (disp_valid) begin
                    if (disp_q.size() == 0) begin
                        chk("disp_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = disp_q.pop_front();
                        chk("disp_data", {24'd0, disp_data}, {24'd0, e.data});
                        chk("disp_latency", cyc, e.due);
                    end
                end else if (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
                    chk("disp_valid_missing", 32'd0, 32'd1);
                    void'(disp_q.pop_front());
                end
                if (game_rvalid) begin
                    if (game_q.size() == 0) begin
                        chk("game_rvalid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = game_q.pop_front();
                        chk("game_rdata", {24'd0, game_rdata}, {24'd0, e.data});
                        chk("game_latency", cyc, e.due);
                    end
                end else if (game_q.size() > 0 && game_q[0].due <= cyc) begin
                    chk("game_rvalid_missing", 32'd0, 32'd1);
                    void'(game_q.pop_front());
                end
            end
        end
    end

    initial begin
        vec_t idle;
        vec_t v;
        cyc = 0; checks = 0; errors = 0;
        pre_en = 1'b0; pre_addr = 16'h0; pre_data = 8'h0;
        idle = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0};

        //            dreq  daddr     greq  gwe   gaddr     gwd    edg   egg
        vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'h0000, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 16'h0001, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 8'h3C, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 8'h77, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};

        // Reset with both requests pending: grants and registered outputs must be 0.
        RST_N = 1'b0;
        v = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h4321, 8'hEE, 1'b0, 1'b0};
        drive(v);
        preload(16'h0010, 8'hA5);
        preload(16'h0000, 8'h11);
        preload(16'h0001, 8'h22);
        preload(16'h0002, 8'h33);
        @(negedge CLK);
        chk("rst_disp_gnt", {31'd0, disp_gnt}, 32'd0);
        chk("rst_game_gnt", {31'd0, game_gnt}, 32'd0);
        chk("rst_sram_address", {16'd0, sram_address}, 32'd0);
        chk("rst_sram_enable", {31'd0, sram_enable}, 32'd0);
        chk("rst_sram_wdata", {24'd0, sram_wdata}, 32'd0);
        chk("rst_valids", {30'd0, disp_valid, game_rvalid}, 32'd0);
        drive(idle);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_row(vecs[i], i);
        end

        // Write then read of the same address: one-cycle write strobe, new data returned.
        v = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0104, 8'h3C, 1'b0, 1'b1};
        run_row(v, 100);
        v = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0104, 8'h00, 1'b0, 1'b1};
        run_row(v, 101);
        chk("wr_sram_enable", {31'd0, sram_enable}, 32'd1);
        chk("wr_sram_address", {16'd0, sram_address}, 32'h0104);
        chk("wr_sram_wdata", {24'd0, sram_wdata}, 32'h3C);
        for (int i = 0; i < 4; i++) begin
            run_row(idle, 102 + i);
            chk("idle_sram_enable", {31'd0, sram_enable}, 32'd0);
            chk("idle_sram_address", {16'd0, sram_address}, 32'h0104);
        end

        // Reset while a display read is in flight: it must never report valid.
        v = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};
        run_row(v, 200);
        @(posedge CLK);
        #1;
        drive(idle);
        @(negedge CLK);
        RST_N = 1'b0;
        disp_q.delete();
        game_q.delete();
        v = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b0, 1'b0};
        drive(v);
        #1;
        chk("midrst_disp_gnt", {31'd0, disp_gnt}, 32'd0);
        chk("midrst_game_gnt", {31'd0, game_gnt}, 32'd0);
        chk("midrst_sram_address", {16'd0, sram_address}, 32'd0);
        chk("midrst_sram_enable", {31'd0, sram_enable}, 32'd0);
        chk("midrst_valids", {30'd0, disp_valid, game_rvalid}, 32'd0);
        drive(idle);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_rst_no_valid", {30'd0, disp_valid, game_rvalid}, 32'd0);
        end

        repeat (3) @(negedge CLK);
        chk("disp_q_drained", disp_q.size(), 32'd0);
        chk("game_q_drained", game_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer in front of the single-port synchronous `sram`. It shares the memory between the VGA display read path and the game-logic read/write path. The display has priority. A starvation counter guarantees the game path a slot within a bounded number of cycles. The block registers every SRAM control signal and routes each read return to the requester that issued it.

## Interface
- `ADDRESS_WIDTH`, 16, SRAM address width (framebuffer 224×180 fits).
- `DATA_WIDTH`, 8, SRAM word width.
- `MAX_WAIT`, 4, maximum consecutive cycles a pending game request is denied (≥1).
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `disp_req`  in  1  display read request.
- `disp_addr`  in  ADDRESS_WIDTH  display read address.
- `disp_gnt`  out  1  display request accepted this cycle (combinational).
- `disp_valid`  out  1  display read data valid.
- `disp_data`  out  DATA_WIDTH  display read data.
- `game_req`  in  1  game access request.
- `game_we`  in  1  1 = write, 0 = read.
- `game_addr`  in  ADDRESS_WIDTH  game address.
- `game_wdata`  in  DATA_WIDTH  game write data.
- `game_gnt`  out  1  game request accepted this cycle (combinational).
- `game_rvalid`  out  1  game read data valid.
- `game_rdata`  out  DATA_WIDTH  game read data.
- `sram_address`  out  ADDRESS_WIDTH  registered, to `sram.address`.
- `sram_enable`  out  1  registered write enable, to `sram.enable`.
- `sram_wdata`  out  DATA_WIDTH  registered, to `sram.sram_in`.
- `sram_rdata`  in  DATA_WIDTH  from `sram.sram_out`.

## Operation
**Handshake**
- A transfer occurs on a rising edge where `req && gnt` holds.
- A requester holds `req`, `addr`, `we` and `wdata` stable until granted.

**Arbitration**
- `force_game = game_req && (wait_cnt >= MAX_WAIT)`.
- `game_gnt = RST_N && game_req && (!disp_req || force_game)`.
- `disp_gnt = RST_N && disp_req && !force_game`.
- At most one grant is high in any cycle.
- `wait_cnt` (width clog2(MAX_WAIT+1)) updates each edge:
  - clears when `game_req` is low or `game_gnt` is high;
  - increments when `game_req` is high and `game_gnt` is low;
  - saturates at MAX_WAIT.

**Issue stage** (edge of an accepted transfer)
- Display grant: `sram_address <= disp_addr`, `sram_enable <= 0`, tag <= DISP.
- Game read grant: `sram_address <= game_addr`, `sram_enable <= 0`, tag <= GAME.
- Game write grant: `sram_address <= game_addr`, `sram_wdata <= game_wdata`, `sram_enable <= 1`, tag <= NONE.
- No grant: `sram_enable <= 0`, tag <= NONE, `sram_address` and `sram_wdata` hold.
- A write therefore drives `sram_enable` high for exactly one cycle unless another write follows.

**Return stage**
- Next edge: `disp_valid <= (tag==DISP)` and `game_rvalid <= (tag==GAME)`.
- `disp_data` and `game_rdata` both pass `sram_rdata` through combinationally. Data is meaningful only while the matching valid is high.

**Ordering**
- Accesses execute in grant order.
- A game write granted at edge k followed by any read of the same address granted at edge k+1 returns the new data.

**Reset**
- Asynchronous on `RST_N` low.
- `sram_address`, `sram_wdata` = 0; `sram_enable` = 0; tag = NONE; `wait_cnt` = 0; `disp_valid`, `game_rvalid` = 0.
- Both grants are forced low while `RST_N` is low.
- Reads in flight when reset asserts are dropped and never signal valid.

## Timing
- Throughput is one access per cycle, for either requester.
- Read latency: a transfer accepted at edge k is registered to the SRAM at k, executed by the SRAM at k+1, and reported with valid high during the cycle after k+1, for exactly one cycle.
- Write: memory is updated at edge k+1; no response is returned.
- Worst-case game wait under continuous display traffic is MAX_WAIT denied cycles, then a grant in the next cycle.
- Display service under continuous game pressure: when both request every cycle, the display is denied 1 cycle in every MAX_WAIT+1.
- Between transfers, the SRAM performs harmless reads at the held address.

## Test plan
1. **Reset values.** Assert `RST_N` low mid-stream while a display read is in flight -> all outputs 0 immediately. After release, no `disp_valid` for the dropped read.
2. **Display read latency.** Preload address 0x0010 = 0xA5; `disp_req` at 0x0010 for one cycle -> `disp_gnt` high that cycle; `disp_valid`=1 with `disp_data`=0xA5 exactly one cycle after the accept edge.
3. **Write then read.** Game writes 0x3C to 0x0100, then game reads 0x0100 on the next cycle -> `sram_enable` high for 1 cycle; `game_rvalid`=1 with 0x3C.
4. **Starvation bound.** `disp_req` held high continuously; `game_req` (read 0x0002) raised at cycle 0 with MAX_WAIT=4 -> `game_gnt` low for cycles 0–3, high in cycle 4; `disp_gnt` low only in cycle 4; `wait_cnt` returns to 0.
5. **Tag routing.** Interleave display reads of 0x0000/0x0001 with a game read of 0x0002 (contents 0x11/0x22/0x33) -> each value appears only on its requester's valid, in grant order, with no valid on the other port.
6. **Idle.** Both requests low -> no valids and `sram_enable`=0; `sram_address` holds its last value.
